// File: rtl/ibus_word_bridge_pkg.sv
// Shared types for the instruction-bus word bridge: fetch bus structs, FSM states, line-buffer entry.
package ibus_bridge_pkg;

    localparam int WORD_BYTES  = 4;
    localparam int FETCH_BYTES = 8;
    localparam int WORD_SHIFT  = $clog2(WORD_BYTES);
    localparam int FETCH_SHIFT = $clog2(FETCH_BYTES);

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } ibus_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [28:0] tag;
        logic [63:0] data;
    } linebuf_entry_t;

endpackage

// File: rtl/ibus_word_bridge_if.sv
// Fetch-side request/response plus the 32-bit memory read port of the bridge.
interface ibus_word_bridge_if;
    import ibus_bridge_pkg::*;

    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        ibuf_inval;

    modport slave (
        input  ireq,
        output iresp,
        output mem_req,
        output mem_addr,
        input  mem_addr_ok,
        input  mem_data_ok,
        input  mem_rdata,
        input  ibuf_inval
    );

    modport master (
        output ireq,
        input  iresp,
        input  mem_req,
        input  mem_addr,
        output mem_addr_ok,
        output mem_data_ok,
        output mem_rdata,
        output ibuf_inval
    );

endinterface

// File: rtl/ibus_word_bridge_linebuf.sv
// One-entry fetch line buffer: tag compare, fill on response, invalidate (used with IBUS_LINEBUF_EN).
module ibus_linebuf
    import ibus_bridge_pkg::*;
#(
    parameter logic [31:0] RESET_TAG = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [28:0] lookup_tag,
    input  logic        start,
    input  logic        fill,
    input  logic [28:0] fill_tag,
    input  logic [63:0] fill_data,
    input  logic        inval,
    output logic        hit,
    output logic [63:0] hit_data
);

    linebuf_entry_t entry_reg, entry_next;
    logic           block_reg, block_next;

    // An invalidate seen anywhere between accept and fill keeps the fill from going valid.
    always_comb begin
        entry_next = entry_reg;
        block_next = block_reg;
        if (start) begin
            block_next = inval;
        end else if (inval) begin
            block_next = 1'b1;
        end
        if (fill) begin
            entry_next.tag   = fill_tag;
            entry_next.data  = fill_data;
            entry_next.valid = !(inval || block_reg);
        end else if (inval) begin
            entry_next.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            entry_reg <= {1'b0, RESET_TAG[31:3], 64'h0};
            block_reg <= 1'b0;
        end else begin
            entry_reg <= entry_next;
            block_reg <= block_next;
        end
    end

    assign hit      = entry_reg.valid && (entry_reg.tag == lookup_tag);
    assign hit_data = entry_reg.data;

endmodule

// File: rtl/ibus_word_bridge.sv
// Turns one 64-bit instruction fetch into two in-order 32-bit memory reads.
// Optional one-entry line buffer enabled by defining IBUS_LINEBUF_EN.
module ibus_word_bridge
    import ibus_bridge_pkg::*;
#(
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_TAG       = 32'hbfc00000
) (
    input logic               clk,
    input logic               resetn,
    ibus_word_bridge_if.slave bus
);

    localparam logic [1:0] MAX_OUT = 2'(MAX_OUTSTANDING);

    state_t                  state_reg, state_next;
    logic [31:FETCH_SHIFT]   base_reg, base_next;
    logic [1:0]              issued_reg, issued_next;
    logic [1:0]              received_reg, received_next;
    logic                    accept, issue_ok, issue_fire, data_take;
    logic                    hit;
    logic [63:0]             hit_data;
    logic [63:0]             line_data;
    logic                    resp_data_ok;

    assign accept     = (state_reg == IDLE) && bus.ireq.valid;
    assign issue_ok   = (state_reg == REQ) && (issued_reg != 2'd2)
                        && ((issued_reg - received_reg) < MAX_OUT);
    assign issue_fire = issue_ok && bus.mem_addr_ok;
    // Stray read data outside an active fetch is dropped rather than corrupting the line.
    assign data_take  = bus.mem_data_ok && ((state_reg == REQ) || (state_reg == WAIT))
                        && (received_reg != 2'd2);

`ifdef IBUS_LINEBUF_EN
    ibus_linebuf #(
        .RESET_TAG (RESET_TAG)
    ) u_linebuf (
        .clk        (clk),
        .resetn     (resetn),
        .lookup_tag (bus.ireq.addr[31:3]),
        .start      (accept),
        .fill       (state_reg == RESP),
        .fill_tag   (base_reg),
        .fill_data  (line_data),
        .inval      (bus.ibuf_inval),
        .hit        (hit),
        .hit_data   (hit_data)
    );
`else
    logic unused_linebuf;
    assign hit            = 1'b0;
    assign hit_data       = '0;
    assign unused_linebuf = ^{RESET_TAG, bus.ibuf_inval};
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.ireq.addr[FETCH_SHIFT-1:0];

    always_comb begin
        state_next    = state_reg;
        base_next     = base_reg;
        issued_next   = issued_reg;
        received_next = received_reg;
        case (state_reg)
            IDLE: begin
                if (bus.ireq.valid) begin
                    base_next   = bus.ireq.addr[31:FETCH_SHIFT];
                    issued_next = 2'd0;
                    if (hit) begin
                        received_next = 2'd2;
                        state_next    = RESP;
                    end else begin
                        received_next = 2'd0;
                        state_next    = REQ;
                    end
                end
            end
            REQ, WAIT: begin
                issued_next   = issued_reg + {1'b0, issue_fire};
                received_next = received_reg + {1'b0, data_take};
                if (received_next == 2'd2) begin
                    state_next = RESP;
                end else if (issued_next == 2'd2) begin
                    state_next = WAIT;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            base_reg     <= '0;
            issued_reg   <= 2'd0;
            received_reg <= 2'd0;
        end else begin
            state_reg    <= state_next;
            base_reg     <= base_next;
            issued_reg   <= issued_next;
            received_reg <= received_next;
        end
    end

    // Word gi of the line is written by the gi-th read response, or by a buffer hit.
    for (genvar gi = 0; gi < 2; gi++) begin : g_word
        logic [31:0] word_reg;
        always_ff @(posedge clk) begin
            if (!resetn) begin
                word_reg <= '0;
            end else if (accept && hit) begin
                word_reg <= hit_data[gi*32 +: 32];
            end else if (data_take && (received_reg == 2'(gi))) begin
                word_reg <= bus.mem_rdata;
            end
        end
        assign line_data[gi*32 +: 32] = word_reg;
    end

    assign resp_data_ok = resetn && (state_reg == RESP);

    always_comb begin
        bus.iresp         = '0;
        bus.iresp.addr_ok = resetn && accept;
        bus.iresp.data_ok = resp_data_ok;
        if (resp_data_ok) begin
            bus.iresp.data = line_data;
        end
    end

    assign bus.mem_req  = resetn && issue_ok;
    assign bus.mem_addr = (resetn && (state_reg == REQ))
                          ? ({base_reg, {FETCH_SHIFT{1'b0}}} + (32'(issued_reg) << WORD_SHIFT))
                          : 32'h0;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (!(bus.mem_data_ok && ((state_reg == IDLE) || (received_reg == 2'd2))));
        end
    end
`endif

endmodule

// File: tb/tb_ibus_word_bridge.sv
// Directed plus randomized fetches against a behavioural memory and line-buffer model.
module tb_ibus_word_bridge;
    import ibus_bridge_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    ibus_word_bridge_if bus();

    ibus_word_bridge dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory model knobs and logs
    int          mem_lat = 1;
    int          stall_pct = 0;
    int          stall_w1 = 0;
    int          last_due = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] acc_q[$];
    logic [31:0] req_log[$];
    int          aok_q[$];
    int          dok_q[$];
    logic [63:0] dat_q[$];
    bit          mm_go;
    int          mm_due;

    bit          mdl_valid = 1'b0;
    logic [28:0] mdl_tag = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hbfc00000) return 32'h11111111;
        if (a == 32'hbfc00004) return 32'h22222222;
        return (a * 32'h9e3779b1) ^ 32'h3c6ef372;
    endfunction

    function automatic logic [63:0] line_of(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:3], 3'b000};
        return {mem_word(b + 32'd4), mem_word(b)};
    endfunction

    always @(negedge clk) begin
        if (!resetn) begin
            pend_addr.delete();
            pend_due.delete();
            last_due = 0;
            bus.mem_data_ok = 1'b0;
            bus.mem_addr_ok = 1'b0;
        end else begin
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                bus.mem_data_ok = 1'b1;
                bus.mem_rdata = mem_word(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                bus.mem_data_ok = 1'b0;
                bus.mem_rdata = 32'hdeadbeef;
            end
            mm_go = 1'b1;
            if (bus.mem_req && bus.mem_addr[2] && stall_w1 > 0) begin
                mm_go = 1'b0;
                stall_w1 = stall_w1 - 1;
            end else if (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) begin
                mm_go = 1'b0;
            end
            bus.mem_addr_ok = mm_go;
            if (bus.mem_req) req_log.push_back(bus.mem_addr);
            if (bus.mem_req && mm_go) begin
                mm_due = cyc + mem_lat;
                if (mm_due <= last_due) mm_due = last_due + 1;
                last_due = mm_due;
                pend_addr.push_back(bus.mem_addr);
                pend_due.push_back(mm_due);
                acc_q.push_back(bus.mem_addr);
            end
        end
        if (bus.iresp.addr_ok) aok_q.push_back(cyc);
        if (bus.iresp.data_ok) begin
            dok_q.push_back(cyc);
            dat_q.push_back(bus.iresp.data);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        acc_q.delete();
        req_log.delete();
        aok_q.delete();
        dok_q.delete();
        dat_q.delete();
    endtask

    task automatic pulse_inval();
        bus.ibuf_inval = 1'b1;
        @(posedge clk); #1;
        bus.ibuf_inval = 1'b0;
        mdl_valid = 1'b0;
    endtask

    // Called and returns at posedge+1.
    task automatic do_fetch(input logic [31:0] addr, input bit exp_hit, input int exp_lat,
                            input bit inval_mid, input string tag);
        bit ok;
        int lat;
        logic [31:0] base;
        base = {addr[31:3], 3'b000};
        clear_logs();
        bus.ireq.valid = 1'b1;
        bus.ireq.addr = addr;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (aok_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        bus.ireq.valid = 1'b0;
        bus.ireq.addr = $urandom;
        if (inval_mid) begin
            bus.ibuf_inval = 1'b1;
            @(posedge clk); #1;
            bus.ibuf_inval = 1'b0;
        end
        for (int i = 0; i < 80 && dok_q.size() == 0; i++) @(negedge clk);
        ok = ok && (dok_q.size() > 0);
        repeat (3) @(negedge clk);
        check({tag, ".completed"}, ok, 1'b1);
        if (ok) begin
            lat = dok_q[0] - aok_q[0];
            check({tag, ".data"}, dat_q[0], line_of(addr));
            if (exp_lat >= 0) check({tag, ".latency"}, lat, exp_lat);
        end else begin
            lat = -1;
        end
        check({tag, ".data_ok_count"}, dok_q.size(), 1);
        if (exp_hit) begin
            check({tag, ".reads"}, acc_q.size(), 0);
        end else begin
            check({tag, ".reads"}, acc_q.size(), 2);
            if (acc_q.size() == 2) begin
                check({tag, ".addr0"}, acc_q[0], base);
                check({tag, ".addr1"}, acc_q[1], base + 32'd4);
            end
        end
        $display("fetch %-12s addr=%h hit=%0d lat=%0d reads=%0d data=%h", tag, addr, exp_hit, lat,
                 acc_q.size(), (dat_q.size() > 0) ? dat_q[0] : 64'h0);
        mdl_valid = !inval_mid;
        mdl_tag = addr[31:3];
        @(posedge clk); #1;
    endtask

    logic [31:0] pool[4];
    logic [31:0] raddr;
    bit          rhit;
    bit          rinval;
    int          rlat;

    initial begin
        bus.ireq = '0;
        bus.ibuf_inval = 1'b0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata = '0;
        resetn = 1'b0;
        bus.ireq.valid = 1'b1;
        bus.ireq.addr = 32'hbfc00000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset.addr_ok", bus.iresp.addr_ok, 1'b0);
            check("reset.data_ok", bus.iresp.data_ok, 1'b0);
            check("reset.mem_req", bus.mem_req, 1'b0);
        end
        check("reset.data", bus.iresp.data, 64'h0);
        check("reset.mem_addr", bus.mem_addr, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        bus.ireq.valid = 1'b0;
        @(negedge clk);
        check("idle.mem_req", bus.mem_req, 1'b0);
        $display("reset done at cycle %0d", cyc);
        @(posedge clk); #1;

        do_fetch(32'hbfc00004, 1'b0, 4, 1'b0, "basic");

        stall_w1 = 3;
        do_fetch(32'h40000008, 1'b0, 7, 1'b0, "stall");
        check("stall.req_cycles", req_log.size(), 5);
        if (req_log.size() == 5) begin
            for (int i = 1; i < 5; i++) check("stall.held_addr", req_log[i], 32'h4000000c);
        end

        // address switched mid-fetch with valid held high
        clear_logs();
        bus.ireq.valid = 1'b1;
        bus.ireq.addr = 32'hbfc00000;
        for (int i = 0; i < 20 && aok_q.size() == 0; i++) @(negedge clk);
        repeat (2) @(posedge clk);
        #1;
        bus.ireq.addr = 32'h80000010;
        for (int i = 0; i < 40 && aok_q.size() < 2; i++) @(negedge clk);
        @(posedge clk); #1;
        bus.ireq.valid = 1'b0;
        for (int i = 0; i < 40 && dok_q.size() < 2; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("switch.data_ok_count", dok_q.size(), 2);
        check("switch.accept_count", aok_q.size(), 2);
        check("switch.reads", acc_q.size(), 4);
        if (dok_q.size() >= 1) check("switch.first_data", dat_q[0], 64'h22222222_11111111);
        if (dok_q.size() >= 1 && aok_q.size() >= 2)
            check("switch.reaccept_cycle", aok_q[1], dok_q[0] + 1);
        if (dok_q.size() >= 2) check("switch.second_data", dat_q[1], line_of(32'h80000010));
        if (acc_q.size() == 4) begin
            check("switch.addr2", acc_q[2], 32'h80000010);
            check("switch.addr3", acc_q[3], 32'h80000014);
        end
        $display("fetch switch       bfc00000 -> 80000010 data_ok=%0d", dok_q.size());
        mdl_valid = 1'b1;
        mdl_tag = 29'(32'h80000010 >> 3);
        @(posedge clk); #1;

`ifdef IBUS_LINEBUF_EN
        do_fetch(32'h80000014, 1'b1, 1, 1'b0, "lb_hit");
        pulse_inval();
        do_fetch(32'h80000010, 1'b0, 4, 1'b0, "lb_inval");
`endif

        // reset while both reads are outstanding
        mem_lat = 4;
        clear_logs();
        bus.ireq.valid = 1'b1;
        bus.ireq.addr = 32'h00002000;
        for (int i = 0; i < 20 && aok_q.size() == 0; i++) @(negedge clk);
        @(posedge clk); #1;
        bus.ireq.valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midreset.reads_issued", acc_q.size(), 2);
        resetn = 1'b0;
        @(negedge clk);
        check("midreset.mem_req", bus.mem_req, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b1;
        mdl_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("midreset.no_data_ok", dok_q.size(), 0);
        $display("reset mid-fetch at cycle %0d, data_ok seen=%0d", cyc, dok_q.size());
        @(posedge clk); #1;
        mem_lat = 1;
        do_fetch(32'h00002000, 1'b0, 4, 1'b0, "post_reset");

        pulse_inval();
        pool[0] = 32'h00001000;
        pool[1] = 32'h00001008;
        pool[2] = 32'h80000040;
        pool[3] = 32'hbfc00100;
        for (int n = 0; n < 40; n++) begin
            raddr = pool[$urandom_range(3)] | 32'($urandom_range(7));
            mem_lat = int'($urandom_range(1, 3));
            stall_pct = ($urandom_range(2) == 0) ? 30 : 0;
            rinval = ($urandom_range(9) == 0);
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
            if ($urandom_range(7) == 0) pulse_inval();
`ifdef IBUS_LINEBUF_EN
            rhit = mdl_valid && (mdl_tag == raddr[31:3]);
`else
            rhit = 1'b0;
`endif
            rlat = rhit ? 1 : ((mem_lat == 1 && stall_pct == 0) ? 4 : -1);
            do_fetch(raddr, rhit, rlat, rinval, "random");
        end
        stall_pct = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
